// File: rtl/cav4_freq_pkg.sv
// Shared widths and FSM encoding for the cavity coarse-frequency slew block.
package cav4_freq_pkg;

  localparam int unsigned FREQ_W  = 28;
  localparam int unsigned STEP_W  = 20;
  localparam int unsigned DWELL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2
  } state_e;

endpackage

// File: rtl/cav4_freq_step_calc.sv
// Saturating toward-target step: moves cur toward tgt by min(step_eff, |tgt-cur|).
module cav4_freq_step_calc
  import cav4_freq_pkg::*;
(
  input  logic signed [FREQ_W-1:0] cur,
  input  logic signed [FREQ_W-1:0] tgt,
  input  logic        [STEP_W-1:0] step,
  output logic signed [FREQ_W-1:0] next,
  output logic                     hit
);

  logic signed [FREQ_W:0] diff;
  logic        [FREQ_W:0] mag;
  logic        [FREQ_W:0] step_eff;

  always_comb begin
    // One guard bit keeps the full-scale difference from wrapping.
    diff     = {tgt[FREQ_W-1], tgt} - {cur[FREQ_W-1], cur};
    mag      = diff[FREQ_W] ? unsigned'(-diff) : unsigned'(diff);
    step_eff = (step == '0) ? (FREQ_W+1)'(1) : (FREQ_W+1)'(step);
    hit      = (mag <= step_eff);
    if (hit) begin
      next = tgt;
    end else if (diff[FREQ_W]) begin
      next = cur - FREQ_W'(step_eff);
    end else begin
      next = cur + FREQ_W'(step_eff);
    end
  end

endmodule

// File: rtl/cav4_freq_slew.sv
// Coarse cavity frequency slew controller: steps toward a target with a dwell between updates.
module cav4_freq_slew
  import cav4_freq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  input  logic                      abort,
  input  logic signed [FREQ_W-1:0]  target,
  input  logic        [STEP_W-1:0]  step,
  input  logic        [DWELL_W-1:0] dwell,
  input  logic                      load,
  input  logic signed [FREQ_W-1:0]  load_val,
  output logic signed [FREQ_W-1:0]  coarse_freq,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted
);

  state_e                    state_q, state_d;
  logic signed [FREQ_W-1:0]  coarse_q, coarse_d;
  logic signed [FREQ_W-1:0]  tgt_q, tgt_d;
  logic        [STEP_W-1:0]  step_q, step_d;
  logic        [DWELL_W-1:0] dwell_q, dwell_d;
  logic        [DWELL_W-1:0] cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;

  logic signed [FREQ_W-1:0]  calc_next;
  logic                      calc_hit;

  cav4_freq_step_calc u_step_calc (
    .cur  (coarse_q),
    .tgt  (tgt_q),
    .step (step_q),
    .next (calc_next),
    .hit  (calc_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      coarse_q  <= '0;
      tgt_q     <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      coarse_q  <= coarse_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    coarse_d  = coarse_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // load has priority over go; abort vetoes go.
        if (load) begin
          coarse_d = load_val;
        end else if (go && !abort) begin
          tgt_d   = target;
          step_d  = step;
          dwell_d = dwell;
          if (target == coarse_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_DWELL;
            cnt_d   = dwell;
          end
        end
      end
      ST_DWELL: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_STEP;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      ST_STEP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          coarse_d = calc_next;
          if (calc_hit) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DWELL;
            cnt_d   = dwell_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign coarse_freq = coarse_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_cav4_freq_slew.sv
// Directed self-checking bench for cav4_freq_slew.
module tb_cav4_freq_slew;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               go, abort, load;
  logic signed [27:0] target, load_val;
  logic        [19:0] step;
  logic        [15:0] dwell;
  logic signed [27:0] coarse_freq;
  logic               busy, done, aborted;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  longint      exp_q[$];

  cav4_freq_slew dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .abort       (abort),
    .target      (target),
    .step        (step),
    .dwell       (dwell),
    .load        (load),
    .load_val    (load_val),
    .coarse_freq (coarse_freq),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_slew(input longint tg, input longint st, input longint dw);
    target = 28'(tg);
    step   = 20'(st);
    dwell  = 16'(dw);
    go     = 1'b1;
    tick();
    go     = 1'b0;
  endtask

  task automatic do_load(input longint v);
    load     = 1'b1;
    load_val = 28'(v);
    tick();
    load     = 1'b0;
  endtask

  // Walk through the expected update sequence in exp_q: dw+1 hold cycles then one update.
  task automatic run_expect(input longint start, input int dw);
    longint prev;
    int     last;
    prev = start;
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      for (int h = 0; h <= dw; h++) begin
        tick();
        chk("hold_freq", coarse_freq, prev);
        chk("hold_done", done, 0);
        chk("hold_busy", busy, 1);
      end
      tick();
      chk("upd_freq", coarse_freq, exp_q[i]);
      chk("upd_done", done, (i == last) ? 1 : 0);
      chk("upd_busy", busy, (i == last) ? 0 : 1);
      prev = exp_q[i];
    end
  endtask

  initial begin
    longint m;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; load = 1'b0;
    target = '0; load_val = '0; step = '0; dwell = '0;
    #12;
    chk("rst_freq", coarse_freq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Positive slew, dwell 0
    do_load(1000);
    chk("load_freq", coarse_freq, 1000);
    go_slew(1010, 4, 0);
    chk("go_busy", busy, 1);
    exp_q = '{1004, 1008, 1010};
    run_expect(1000, 0);
    tick();
    chk("done_single", done, 0);

    // Negative slew with dwell 5, final partial step
    do_load(0);
    go_slew(-10, 3, 5);
    exp_q = '{-3, -6, -9, -10};
    run_expect(0, 5);
    tick();
    chk("neg_done_once", done, 0);
    chk("neg_final", coarse_freq, -10);

    // Full-scale slew: 256 full steps then a 255 remainder
    do_load(134217727);
    go_slew(-134217728, 1048575, 0);
    exp_q = {};
    m = 134217727;
    while (m != -134217728) begin
      m = (m - 1048575 < -134217728) ? -134217728 : m - 1048575;
      exp_q.push_back(m);
    end
    chk("fs_nsteps", exp_q.size(), 257);
    run_expect(134217727, 0);

    // Mid-slew abort
    do_load(0);
    go_slew(100, 10, 3);
    exp_q = '{10};
    for (int h = 0; h < 5; h++) tick();
    chk("ab_first_step", coarse_freq, 10);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_pulse", aborted, 1);
    chk("ab_done", done, 0);
    chk("ab_freq", coarse_freq, 10);
    tick();
    chk("ab_pulse_once", aborted, 0);
    for (int h = 0; h < 5; h++) tick();
    chk("ab_frozen", coarse_freq, 10);
    chk("ab_idle", busy, 0);

    // Abort in IDLE does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort", aborted, 0);

    // go and abort together: go dropped
    target = 28'(50); go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    chk("goab_busy", busy, 0);
    chk("goab_done", done, 0);
    chk("goab_aborted", aborted, 0);
    tick();
    chk("goab_busy2", busy, 0);
    chk("goab_freq", coarse_freq, 10);

    // load while busy ignored
    go_slew(20, 1, 9);
    do_load(777);
    chk("busyload_freq", coarse_freq, 10);
    chk("busyload_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("busyload_abort", aborted, 1);

    // load and go together in IDLE: load wins
    target = 28'(99); step = 20'(1); dwell = 16'(0);
    load_val = 28'(40); load = 1'b1; go = 1'b1;
    tick();
    load = 1'b0; go = 1'b0;
    chk("loadgo_freq", coarse_freq, 40);
    chk("loadgo_busy", busy, 0);
    do_load(10);

    // step=0 acts as unit step; go while busy ignored
    go_slew(13, 0, 0);
    tick();
    chk("u_hold", coarse_freq, 10);
    target = 28'(500); step = 20'(100); go = 1'b1;
    tick();
    go = 1'b0;
    chk("u_step1", coarse_freq, 11);
    exp_q = '{12, 13};
    run_expect(11, 0);
    for (int h = 0; h < 4; h++) tick();
    chk("u_stay", coarse_freq, 13);
    chk("u_idle", busy, 0);

    // go with target equal to current value: immediate done
    go_slew(13, 5, 5);
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 0);
    tick();
    chk("eq_done_once", done, 0);
    chk("eq_freq", coarse_freq, 13);

    // Asynchronous reset mid-slew
    do_load(0);
    go_slew(1000, 1, 0);
    for (int h = 0; h < 6; h++) tick();
    chk("pre_rst_freq", coarse_freq, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_freq", coarse_freq, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_aborted", aborted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int h = 0; h < 6; h++) begin
      tick();
      chk("post_rst_done", done, 0);
      chk("post_rst_aborted", aborted, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_freq", coarse_freq, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cav4_freq_slew.md
CAV4_FREQ_SLEW -- requirements
Module: cav4_freq_slew

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, listed below first.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous assert, active-low reset; release is synchronous to clk.
REQ-004 go  in  1  single-cycle strobe; starts a slew to target.
REQ-005 abort  in  1  level/strobe; stops an active slew at the current value.
REQ-006 target  in  28 signed  requested coarse frequency; sampled on accepted go.
REQ-007 step  in  20 unsigned  maximum change per update; sampled on accepted go.
REQ-008 dwell  in  16 unsigned  idle cycles between updates; sampled on accepted go.
REQ-009 load  in  1  strobe; immediate write of load_val when IDLE.
REQ-010 load_val  in  28 signed  value for load.
REQ-011 coarse_freq  out  28 signed  registered value driving the cavity frequency datapath.
REQ-012 busy  out  1  high in DWELL or STEP.
REQ-013 done  out  1  single-cycle pulse when a slew reaches target.
REQ-014 aborted  out  1  single-cycle pulse when a slew is terminated by abort.

Function
REQ-015 States SHALL be IDLE, DWELL, STEP.
REQ-016 In IDLE, go with abort low SHALL be accepted: latch target, step, dwell; go to DWELL with counter loaded from dwell.
REQ-017 An accepted go where target equals coarse_freq SHALL pulse done on the next cycle and remain in IDLE.
REQ-018 In DWELL the counter SHALL decrement each cycle; at zero the state SHALL go to STEP (dwell=0 gives DWELL for exactly one cycle).
REQ-019 In STEP, diff = target - coarse_freq SHALL be computed at 29 bits signed; no wrap permitted.
REQ-020 In STEP, coarse_freq SHALL move toward target by min(step_eff, |diff|), where step_eff = step if nonzero, else 1.
REQ-021 If the STEP update lands on target, done SHALL pulse in the same cycle coarse_freq first equals target, and the state SHALL go to IDLE; otherwise the state SHALL return to DWELL with the counter reloaded.
REQ-022 The update period SHALL therefore be dwell+2 cycles per step; coarse_freq SHALL never overshoot target.
REQ-023 go while busy SHALL be ignored; latched parameters SHALL not change mid-slew.
REQ-024 abort while busy SHALL enter IDLE next cycle, hold coarse_freq unchanged, and pulse aborted once; abort in IDLE SHALL have no effect.
REQ-025 If go and abort coincide, abort SHALL win and go SHALL be dropped.
REQ-026 load in IDLE SHALL set coarse_freq to load_val next cycle; load while busy SHALL be ignored; if load and go coincide in IDLE, load SHALL apply and go SHALL be dropped.
REQ-027 done and aborted SHALL never be high in the same cycle.
REQ-028 Full-scale slew (-2^27 to 2^27-1) SHALL complete without overflow.

Reset
REQ-029 rst_n low SHALL force: state IDLE, coarse_freq 0, busy 0, done 0, aborted 0, counter 0, latched target/step/dwell 0.
REQ-030 Reset asserted mid-slew SHALL abandon the slew with no done or aborted pulse.

Structure
REQ-031 Widths (FREQ_W=28, STEP_W=20, DWELL_W=16) and the state encoding SHALL reside in shared package cav4_freq_pkg.
REQ-032 The saturating toward-target step arithmetic SHALL be a combinational sub-module cav4_freq_step_calc (inputs cur, tgt, step; output next, hit).

Verification
REQ-033 Reset; load 1000; go target=1010 step=4 dwell=0 -> coarse_freq 1004, 1008, 1010 every 2 cycles; done with 1010; busy low after.
REQ-034 coarse_freq=0; go target=-10 step=3 dwell=5 -> -3, -6, -9, -10 at 7-cycle spacing; no overshoot; one done pulse.
REQ-035 go target=-2^27 step=2^20-1 from 2^27-1 -> monotonic decrease, no wrap, final -134217728, done.
REQ-036 Mid-slew abort -> IDLE next cycle, coarse_freq frozen, aborted pulse once; go+abort same cycle in IDLE -> nothing accepted.
REQ-037 go with step=0 target=coarse_freq+3 dwell=0 -> three unit steps, done; go while busy with a new target -> ignored.
REQ-038 rst_n asserted mid-slew -> all outputs 0 immediately (asynchronous), no done/aborted pulse after release.
